// File: rtl/reg_share_arb_pkg.sv
// reg_share_arb_pkg: shared state type and default sizing for the shared-register arbiter.
package reg_share_arb_pkg;
  typedef enum logic {IDLE, OWNED} state_t;
  localparam int NREQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int MAX_HOLD_DEF = 8;
endpackage

// File: rtl/reg_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or above i_ptr, wrapping to 0.
module rr_pick
  import reg_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx
);
  int j;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    j = 0;
    // walk offsets downward so the smallest offset from i_ptr wins
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(i_ptr) + i) % NREQ;
      if (i_req[j]) begin
        o_gnt = '0;
        o_gnt[j] = 1'b1;
        o_idx = ($clog2(NREQ))'(j);
      end
    end
  end
endmodule

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter granting one requester at a time write access to a shared register.
module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
  state_t r_state, w_state_nx;
  logic [NREQ-1:0] r_gnt, w_gnt_nx, w_pick_gnt;
  logic [IW-1:0] r_owner, w_owner_nx, r_ptr, w_ptr_nx, w_pick_ptr, w_pick_idx, w_inc;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic [WIDTH-1:0] r_q, w_q_in;
  logic r_q_valid, w_load, w_keep;

  // on release the search starts just past the outgoing owner, so k is re-picked only if alone
  assign w_inc = r_owner == LAST ? '0 : r_owner + IW'(1);
  assign w_pick_ptr = r_state == OWNED ? w_inc : r_ptr;
  assign w_q_in = wdata[int'(r_owner) * WIDTH +: WIDTH];

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req(req),
    .i_ptr(w_pick_ptr),
    .o_gnt(w_pick_gnt),
    .o_idx(w_pick_idx)
  );

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx = r_gnt;
    w_owner_nx = r_owner;
    w_hold_nx = r_hold;
    w_ptr_nx = r_ptr;
    w_load = r_state == OWNED && req[r_owner];
    w_keep = w_load && lock[r_owner] && r_hold < HMAX;
    if (w_keep) w_hold_nx = r_hold + HW'(1);
    else if (r_state == OWNED || |req) begin
      w_ptr_nx = w_pick_ptr;
      w_state_nx = |req ? OWNED : IDLE;
      w_gnt_nx = w_pick_gnt;
      w_owner_nx = |req ? w_pick_idx : r_owner;
      w_hold_nx = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_owner <= '0;
      r_hold <= '0;
      r_ptr <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt <= w_gnt_nx;
      r_owner <= w_owner_nx;
      r_hold <= w_hold_nx;
      r_ptr <= w_ptr_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      r_q_valid <= 1'b0;
    end else begin
      if (w_load) r_q <= w_q_in;
      r_q_valid <= w_load;
    end
  end

  assign gnt = r_gnt;
  assign q = r_q;
  assign q_valid = r_q_valid;
  assign owner = r_owner;
  assign busy = |r_gnt;
endmodule

// File: tb/tb_reg_share_arb.sv
// tb_reg_share_arb: scoreboard bench; a behavioural model queues expected outputs per edge.
module tb_reg_share_arb;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int MAX_HOLD = 8;

  logic clk, reset;
  logic [NREQ-1:0] req, lock, gnt;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [WIDTH-1:0] q;
  logic q_valid, busy;
  logic [1:0] owner;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] q;
    logic qv;
    logic busy;
    int owner;
  } exp_t;
  exp_t sbq[$];

  int n_vec = 0, n_err = 0;
  bit m_busy, m_qv;
  int m_owner, m_hold, m_ptr;
  logic [7:0] m_q;

  reg_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_qv = 0; m_owner = 0; m_hold = 0; m_ptr = 0; m_q = 0;
  endtask

  task automatic arb(input logic [3:0] r);
    m_busy = 0;
    for (int s = 0; s < NREQ; s++)
      if (!m_busy && r[(m_ptr + s) % NREQ]) begin
        m_owner = (m_ptr + s) % NREQ;
        m_busy = 1;
        m_hold = 0;
      end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [31:0] wd);
    exp_t e;
    int k;
    req = r; lock = l; wdata = wd;
    if (m_busy) begin
      k = m_owner;
      m_qv = r[k];
      if (r[k]) m_q = wd[k*8 +: 8];
      if (r[k] && l[k] && m_hold < MAX_HOLD - 1) m_hold++;
      else begin
        m_ptr = (k + 1) % NREQ;
        arb(r);
      end
    end else begin
      m_qv = 0;
      arb(r);
    end
    e.gnt = m_busy ? 4'(1 << m_owner) : 4'd0;
    e.q = m_q; e.qv = m_qv; e.busy = m_busy; e.owner = m_owner;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("gnt", 32'(gnt), 32'(e.gnt));
    chk("q", 32'(q), 32'(e.q));
    chk("q_valid", 32'(q_valid), 32'(e.qv));
    chk("busy", 32'(busy), 32'(e.busy));
    if (e.busy) chk("owner", 32'(owner), 32'(e.owner));
  endtask

  task automatic do_reset();
    reset = 1; req = 0; lock = 0;
    model_clear();
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);
    chk("rst_owner", 32'(owner), 0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int n;
    bit done;
    logic [31:0] wd;
    logic [3:0] r, l;
    reset = 1; req = 0; lock = 0; wdata = 0;
    model_clear();
    #1;
    chk("init_gnt", 32'(gnt), 0);
    chk("init_busy", 32'(busy), 0);
    chk("init_q", 32'(q), 0);
    @(negedge clk);
    reset = 0;

    // single request, one load, then release
    step(4'b0100, 4'b0000, 32'h00A5_0000);
    chk("s33_gnt", 32'(gnt), 32'h4);
    chk("s33_owner", 32'(owner), 2);
    step(4'b0100, 4'b0000, 32'h00A5_0000);
    chk("s33_q", 32'(q), 32'hA5);
    chk("s33_qv", 32'(q_valid), 1);
    step(4'b0000, 4'b0000, 32'h0);
    chk("s33_idle", 32'(gnt), 0);

    // full rotation with no gaps
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000, $urandom);
      chk("s34_rot", 32'(gnt), 32'(1 << (i % 4)));
    end

    // lock-limited hold
    do_reset();
    n = 0; done = 0;
    for (int i = 0; i < 20; i++)
      if (!done) begin
        step(4'b0011, 4'b0001, $urandom);
        if (gnt == 4'b0001) n++;
        else if (n > 0) done = 1;
      end
    chk("s35_hold", 32'(n), 8);
    chk("s35_next", 32'(gnt), 32'h2);

    // owner drops request while locked
    do_reset();
    step(4'b0010, 4'b0010, 32'h0000_1100);
    step(4'b0010, 4'b0010, 32'h0000_1100);
    chk("s36_q", 32'(q), 32'h11);
    step(4'b0000, 4'b0010, 32'h0000_9900);
    chk("s36_qhold", 32'(q), 32'h11);
    chk("s36_qv", 32'(q_valid), 0);
    chk("s36_gnt", 32'(gnt), 0);

    // async reset mid-ownership, then no load on the release edge
    do_reset();
    step(4'b0010, 4'b0000, 32'h0000_3C00);
    step(4'b0010, 4'b0000, 32'h0000_3C00);
    chk("s37_pre_gnt", 32'(gnt), 32'h2);
    chk("s37_pre_q", 32'(q), 32'h3C);
    #2;
    reset = 1;
    #1;
    chk("s37_gnt", 32'(gnt), 0);
    chk("s37_q", 32'(q), 0);
    chk("s37_busy", 32'(busy), 0);
    do_reset();
    step(4'b0010, 4'b0000, 32'h0000_7700);
    chk("s28_noload", 32'(q_valid), 0);

    // lone requester re-granted each cycle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wd = $urandom;
      step(4'b1000, 4'b0000, wd);
      chk("s38_gnt", 32'(gnt), 32'h8);
    end

    // random traffic, lock often mirrors req to exercise long holds
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 80) == 0) do_reset();
      r = 4'($urandom);
      l = ($urandom_range(0, 3) != 0) ? r : 4'($urandom);
      step(r, l, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
